edge_config_controller: RTL and testbench
=========================================

EDGE_CONFIG_CONTROLLER -- requirements
Module: edge_config_controller

Interface
REQ-001 SHALL have parameter CUT_DEF, default 4'hC, reset value of cutThresh.
REQ-002 SHALL have parameter ABS_DEF, default 4'h6, reset value of absThresh.
REQ-003 SHALL have parameter TOT_DEF, default 4'h8, reset value of totThresh.
REQ-004 SHALL have parameter NUM_DEF, default 4'h3, reset value of numEdgesNeeded.
REQ-005 SHALL have parameter HOLD_CYCLES, default 12_500_000, continuous-hold cycles before the first auto-repeat step.
REQ-006 SHALL have parameter REPEAT_CYCLES, default 2_500_000, cycles between subsequent auto-repeat steps.
REQ-007 SHALL use one clock and a synchronous, active-low reset; all logic on the rising edge of clk25.
REQ-008 SHALL have port clk25  input  1  pixel clock, sole clock.
REQ-009 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-010 SHALL have port btnSel  input  1  debounced, clk25-synchronous level; rise = select next field.
REQ-011 SHALL have port btnUp  input  1  debounced level; rise/hold = increment selected field.
REQ-012 SHALL have port btnDown  input  1  debounced level; rise/hold = decrement selected field.
REQ-013 SHALL have port swEdge  input  1  requested edgeDetectEnable level.
REQ-014 SHALL have port swShift  input  1  requested shiftBrightness level.
REQ-015 SHALL have port vsync  input  1  frame-boundary strobe; rising edge commits configuration.
REQ-016 SHALL have outputs cutThresh, absThresh, totThresh, numEdgesNeeded  output  4 each  active thresholds to the pixel resolver.
REQ-017 SHALL have outputs edgeDetectEnable, shiftBrightness  output  1 each  active mode bits.
REQ-018 SHALL have output selField  output  2  selected field: 0 cut, 1 abs, 2 tot, 3 num.
REQ-019 SHALL have output pending  output  1  high when any shadow value differs from its active output.

Function
REQ-020 SHALL register btnSel/btnUp/btnDown/vsync once; a press/rise = current sample 1 AND previous sample 0.
REQ-021 SHALL implement selection FSM SEL_CUT->SEL_ABS->SEL_TOT->SEL_NUM->SEL_CUT, advancing one state per btnSel press; selField = state encoding.
REQ-022 SHALL hold four 4-bit shadow registers; a step updates only the shadow of the field selected before any same-cycle btnSel advance.
REQ-023 SHALL register the step result: a press sampled at edge k is visible in the shadow after edge k.
REQ-024 SHALL saturate cut/abs/tot shadows at 0 and 15, and numEdgesNeeded shadow at 0 and 8; steps beyond a limit leave the value unchanged.
REQ-025 SHALL treat btnUp and btnDown both high (press or hold) as no step and SHALL clear the hold counter.
REQ-026 SHALL run a hold counter while exactly one of btnUp/btnDown is high: one step when it reaches HOLD_CYCLES, then one step every REPEAT_CYCLES; counter cleared on release.
REQ-027 SHALL sample swEdge/swShift into shadow bits every cycle.
REQ-028 SHALL copy all six shadows to their active outputs in the cycle after vsync rise is detected; outputs SHALL NOT change at any other time.
REQ-029 SHALL, when a step and a vsync commit coincide, commit the pre-step shadow; the step commits at the next vsync rise.
REQ-030 SHALL compute pending combinationally from registered shadow and active values.

Reset
REQ-031 SHALL, with rst_n low at a clock edge, set shadows and active thresholds to CUT_DEF/ABS_DEF/TOT_DEF/NUM_DEF, edgeDetectEnable = shiftBrightness = 0, shadow mode bits = 0, FSM = SEL_CUT, hold counter = 0, pending = 0.
REQ-032 SHALL reset the previous-sample registers of btnSel/btnUp/btnDown/vsync to 1, so levels held through reset generate no press.
REQ-033 SHALL make reset asserted mid-hold or mid-frame discard uncommitted shadow changes immediately.

Verification
REQ-034 Reset, btnSel pulsed 5 times -> selField 0,1,2,3,0,1.
REQ-035 SEL_CUT, 5 btnUp presses, no vsync -> cutThresh stays 4'hC, pending 1; vsync rise -> cutThresh 4'hF one cycle later, pending 0.
REQ-036 SEL_NUM, btnUp held 12 steps' worth (HOLD_CYCLES=4, REPEAT_CYCLES=2 override) -> shadow reaches 8 and stays; btnDown 10 presses -> 0.
REQ-037 btnUp and btnDown rise together -> no shadow change, hold counter 0.
REQ-038 btnUp held through rst_n release -> no step; swEdge=1 then vsync -> edgeDetectEnable 1 only after vsync.
REQ-039 rst_n low mid-hold with pending=1 -> all outputs to defaults, pending 0 next cycle.

Source files
------------

// File: rtl/edge_config_controller.sv
// rtl/edge_config_controller.sv - threshold/mode configuration controller with frame-synchronous commit
//
// Purpose: button-driven editor for four edge-detector thresholds plus two mode
// switches. Edits land in shadow registers and reach the active outputs only on
// a vsync rising edge, so the pixel resolver never sees a mid-frame change.
//
// Ports:
//   clk25            in   pixel clock, sole clock
//   rst_n            in   synchronous active-low reset
//   btnSel           in   rise selects next field (cut -> abs -> tot -> num)
//   btnUp / btnDown  in   rise or hold steps the selected field up / down
//   swEdge / swShift in   requested mode bits, sampled every cycle
//   vsync            in   rising edge commits shadows to active outputs
//   cutThresh, absThresh, totThresh, numEdgesNeeded  out  active thresholds
//   edgeDetectEnable, shiftBrightness                 out  active mode bits
//   selField         out  selected field (0 cut, 1 abs, 2 tot, 3 num)
//   pending          out  some shadow differs from its active output
module edge_config_controller #(
    parameter logic [3:0] CUT_DEF       = 4'hC,
    parameter logic [3:0] ABS_DEF       = 4'h6,
    parameter logic [3:0] TOT_DEF       = 4'h8,
    parameter logic [3:0] NUM_DEF       = 4'h3,
    parameter int         HOLD_CYCLES   = 12_500_000,
    parameter int         REPEAT_CYCLES = 2_500_000
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       btnSel,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       swEdge,
    input  logic       swShift,
    input  logic       vsync,
    output logic [3:0] cutThresh,
    output logic [3:0] absThresh,
    output logic [3:0] totThresh,
    output logic [3:0] numEdgesNeeded,
    output logic       edgeDetectEnable,
    output logic       shiftBrightness,
    output logic [1:0] selField,
    output logic       pending
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(HOLD_CYCLES + REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_BASE  = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        SEL_CUT = 2'd0,
        SEL_ABS = 2'd1,
        SEL_TOT = 2'd2,
        SEL_NUM = 2'd3
    } sel_state_t;

    sel_state_t       selState;
    logic             selPrev, upPrev, downPrev, vsyncPrev;
    logic [3:0]       shCut, shAbs, shTot, shNum;
    logic             shEdge, shShift;
    logic [CNT_W-1:0] holdCnt;

    logic       selPress, upPress, downPress, commit;
    logic       upOnly, downOnly, holdTick, stepUp, stepDown;
    logic [3:0] selVal, fieldMax, stepVal;

    assign selPress  = btnSel & ~selPrev;
    assign upPress   = btnUp & ~upPrev;
    assign downPress = btnDown & ~downPrev;
    assign commit    = vsync & ~vsyncPrev;
    assign upOnly    = btnUp & ~btnDown;
    assign downOnly  = btnDown & ~btnUp;

    // First repeat fires when the counter reaches HOLD_CYCLES; afterwards the
    // counter wraps back to HOLD_CYCLES so each further REPEAT_CYCLES gives a step.
    assign holdTick = (upOnly | downOnly) && (holdCnt == HOLD_LAST || holdCnt == REP_LAST);
    assign stepUp   = upOnly & (upPress | holdTick);
    assign stepDown = downOnly & (downPress | holdTick);

    // Step result for the field selected before any same-cycle btnSel advance.
    always_comb begin
        selVal   = shCut;
        fieldMax = 4'd15;
        case (selState)
            SEL_CUT: selVal = shCut;
            SEL_ABS: selVal = shAbs;
            SEL_TOT: selVal = shTot;
            default: begin
                selVal   = shNum;
                fieldMax = 4'd8;
            end
        endcase
        stepVal = selVal;
        if (stepUp && selVal < fieldMax) begin
            stepVal = selVal + 4'd1;
        end else if (stepDown && selVal != 4'd0) begin
            stepVal = selVal - 4'd1;
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            // Previous samples start high so levels held through reset are not presses.
            selPrev          <= 1'b1;
            upPrev           <= 1'b1;
            downPrev         <= 1'b1;
            vsyncPrev        <= 1'b1;
            selState         <= SEL_CUT;
            holdCnt          <= '0;
            shCut            <= CUT_DEF;
            shAbs            <= ABS_DEF;
            shTot            <= TOT_DEF;
            shNum            <= NUM_DEF;
            shEdge           <= 1'b0;
            shShift          <= 1'b0;
            cutThresh        <= CUT_DEF;
            absThresh        <= ABS_DEF;
            totThresh        <= TOT_DEF;
            numEdgesNeeded   <= NUM_DEF;
            edgeDetectEnable <= 1'b0;
            shiftBrightness  <= 1'b0;
        end else begin
            selPrev   <= btnSel;
            upPrev    <= btnUp;
            downPrev  <= btnDown;
            vsyncPrev <= vsync;
            shEdge    <= swEdge;
            shShift   <= swShift;

            if (selPress) begin
                selState <= sel_state_t'(selState + 2'd1);
            end

            if (upOnly || downOnly) begin
                holdCnt <= (holdCnt == REP_LAST) ? REP_BASE : holdCnt + 1'b1;
            end else begin
                holdCnt <= '0;
            end

            case (selState)
                SEL_CUT: shCut <= stepVal;
                SEL_ABS: shAbs <= stepVal;
                SEL_TOT: shTot <= stepVal;
                default: shNum <= stepVal;
            endcase

            // Commit takes the shadow as it stood before this edge, so a
            // coinciding step waits for the next frame.
            if (commit) begin
                cutThresh        <= shCut;
                absThresh        <= shAbs;
                totThresh        <= shTot;
                numEdgesNeeded   <= shNum;
                edgeDetectEnable <= shEdge;
                shiftBrightness  <= shShift;
            end
        end
    end

    assign selField = selState;
    assign pending  = (shCut != cutThresh) | (shAbs != absThresh) |
                      (shTot != totThresh) | (shNum != numEdgesNeeded) |
                      (shEdge != edgeDetectEnable) | (shShift != shiftBrightness);

endmodule

// File: tb/tb_edge_config_controller.sv
// tb/tb_edge_config_controller.sv - self-checking bench for edge_config_controller
module tb_edge_config_controller;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       btnSel = 1'b0, btnUp = 1'b0, btnDown = 1'b0;
    logic       swEdge = 1'b0, swShift = 1'b0, vsync = 1'b0;
    logic [3:0] cutThresh, absThresh, totThresh, numEdgesNeeded;
    logic       edgeDetectEnable, shiftBrightness, pending;
    logic [1:0] selField;

    always #5 clk25 = ~clk25;

    edge_config_controller #(
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(2)
    ) dut (
        .clk25           (clk25),
        .rst_n           (rst_n),
        .btnSel          (btnSel),
        .btnUp           (btnUp),
        .btnDown         (btnDown),
        .swEdge          (swEdge),
        .swShift         (swShift),
        .vsync           (vsync),
        .cutThresh       (cutThresh),
        .absThresh       (absThresh),
        .totThresh       (totThresh),
        .numEdgesNeeded  (numEdgesNeeded),
        .edgeDetectEnable(edgeDetectEnable),
        .shiftBrightness (shiftBrightness),
        .selField        (selField),
        .pending         (pending)
    );

    typedef struct {
        logic sel, up, dn, sw, vs;
        int   eSel, eCut, eEdge, ePend;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   expQ[$];
    int   nCompared = 0;
    int   nMismatched = 0;
    int   tl[0:23];

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic addVec(input logic sel, input logic up, input logic dn, input logic sw,
                          input logic vs, input int eSel, input int eCut, input int eEdge,
                          input int ePend);
        vec_t v;
        v.sel = sel; v.up = up; v.dn = dn; v.sw = sw; v.vs = vs;
        v.eSel = eSel; v.eCut = eCut; v.eEdge = eEdge; v.ePend = ePend;
        vecs.push_back(v);
    endtask

    task automatic checkDefaults(input string tag);
        check({tag, ".sel"}, selField, 0);
        check({tag, ".cut"}, cutThresh, 4'hC);
        check({tag, ".abs"}, absThresh, 4'h6);
        check({tag, ".tot"}, totThresh, 4'h8);
        check({tag, ".num"}, numEdgesNeeded, 4'h3);
        check({tag, ".edge"}, edgeDetectEnable, 0);
        check({tag, ".shift"}, shiftBrightness, 0);
        check({tag, ".pend"}, pending, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        checkDefaults("reset");
        rst_n = 1'b1;

        // Vector table: idle, 8 select pulses, 5 up presses, commit, mode
        // switch, step/commit collision, both buttons held together.
        addVec(0, 0, 0, 0, 0, 0, 'hC, 0, 0);
        for (int i = 0; i < 8; i++) begin
            addVec(1, 0, 0, 0, 0, (i + 1) % 4, 'hC, 0, 0);
            addVec(0, 0, 0, 0, 0, (i + 1) % 4, 'hC, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            addVec(0, 1, 0, 0, 0, 0, 'hC, 0, 1);
            addVec(0, 0, 0, 0, 0, 0, 'hC, 0, 1);
        end
        addVec(0, 0, 0, 0, 1, 0, 'hF, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 'hF, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 'hF, 0, 1);
        addVec(0, 0, 0, 1, 1, 0, 'hF, 1, 0);
        addVec(0, 0, 0, 0, 0, 0, 'hF, 1, 1);
        addVec(0, 0, 0, 0, 1, 0, 'hF, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 'hF, 0, 0);
        addVec(0, 0, 1, 0, 1, 0, 'hF, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 'hF, 0, 1);
        addVec(0, 0, 0, 0, 1, 0, 'hE, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 'hE, 0, 0);
        for (int i = 0; i < 6; i++) addVec(0, 1, 1, 0, 0, 0, 'hE, 0, 0);
        addVec(0, 0, 0, 0, 1, 0, 'hE, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 'hE, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            btnSel = vecs[i].sel; btnUp = vecs[i].up; btnDown = vecs[i].dn;
            swEdge = vecs[i].sw; vsync = vecs[i].vs;
            sb.push_back(vecs[i]);
            tick();
            e = sb.pop_front();
            check($sformatf("vec%0d.sel", i), selField, e.eSel);
            check($sformatf("vec%0d.cut", i), cutThresh, e.eCut);
            check($sformatf("vec%0d.edge", i), edgeDetectEnable, e.eEdge);
            check($sformatf("vec%0d.pend", i), pending, e.ePend);
        end
        btnSel = 0; btnUp = 0; btnDown = 0; swEdge = 0; vsync = 0;

        // Move to SEL_NUM
        for (int i = 0; i < 3; i++) begin
            btnSel = 1; tick();
            btnSel = 0; tick();
        end
        check("nav.sel", selField, 3);

        // Held btnUp with HOLD=4/REPEAT=2: shadow after edge j of the hold.
        tl = '{4, 4, 4, 5, 5, 6, 6, 7, 7, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
        btnUp = 1;
        for (int j = 0; j < 24; j++) begin
            vsync = (j % 2 == 1);
            if (vsync) expQ.push_back(tl[j - 1]);
            tick();
            if (vsync) check($sformatf("hold%0d.num", j), numEdgesNeeded, expQ.pop_front());
        end
        btnUp = 0; vsync = 0; tick();
        check("hold.pend", pending, 0);

        // 10 down presses saturate at 0
        for (int i = 0; i < 10; i++) begin
            btnDown = 1; tick();
            btnDown = 0; tick();
        end
        check("down.pend", pending, 1);
        check("down.numHeld", numEdgesNeeded, 8);
        vsync = 1; tick();
        check("down.num", numEdgesNeeded, 0);
        check("down.pendAfter", pending, 0);
        vsync = 0; tick();

        // btnUp held through reset release
        btnUp = 1; rst_n = 0; tick(); tick();
        rst_n = 1; tick();
        check("rstHold.pend1", pending, 0);
        tick();
        check("rstHold.pend2", pending, 0);
        check("rstHold.cut", cutThresh, 4'hC);
        btnUp = 0; tick();
        check("rstHold.pend3", pending, 0);

        // swEdge reaches output only after vsync
        swEdge = 1; tick();
        check("sw.edgeBefore", edgeDetectEnable, 0);
        check("sw.pend", pending, 1);
        tick();
        check("sw.edgeStill", edgeDetectEnable, 0);
        vsync = 1; tick();
        check("sw.edgeAfter", edgeDetectEnable, 1);
        vsync = 0;

        // Reset mid-hold with pending changes
        btnUp = 1; tick();
        check("mid.pend", pending, 1);
        vsync = 1; tick();
        check("mid.cut", cutThresh, 4'hD);
        vsync = 0; tick(); tick();
        check("mid.pend2", pending, 1);
        rst_n = 0; tick();
        checkDefaults("midReset");
        rst_n = 1; btnUp = 0; swEdge = 0; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
